sobel_stream: RTL and testbench

SOBEL_STREAM -- requirements
Module: sobel_stream

---
 rtl/sobel_pkg.sv | 19 +
 rtl/sobel_line_buffer.sv | 28 ++
 rtl/sobel_stream.sv | 174 +++++++++++++++++
 tb/tb_sobel_stream.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the streaming Sobel edge detector.
package sobel_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SUM    = 2'd0;
  localparam logic [1:0] MODE_GX     = 2'd1;
  localparam logic [1:0] MODE_GY     = 2'd2;
  localparam logic [1:0] MODE_THRESH = 2'd3;

  localparam int DEF_IMG_W = 720;
  localparam int DEF_IMG_H = 540;
  localparam int DEF_PIX_W = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage; the read returns the old word so the
// same column can be read and overwritten in a single transfer.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = DEF_PIX_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sobel_stream.sv
// FIFO-to-FIFO 3x3 Sobel filter: output (r-1,c-1) is produced while input
// (r,c) is consumed, so the live column comes straight from the line buffers.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [PIX_W-1:0] pixel_in,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [PIX_W-1:0] sobel_pixel,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] threshold,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;
  localparam int MW = PIX_W + 4;
  localparam logic [CW-1:0]    LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    LAST_ROW = RW'(IMG_H - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  state_t           state;
  logic [CW-1:0]    in_col, out_col;
  logic [RW-1:0]    in_row, out_row;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] thresh_q;

  // Window columns: index 0 = top (row r-2), 2 = bottom (row r)
  logic [PIX_W-1:0] left_col   [3];
  logic [PIX_W-1:0] centre_col [3];
  logic [PIX_W-1:0] col_new    [3];
  logic [PIX_W-1:0] lb1_out, lb2_out;

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        abs_x, abs_y;
  logic [MW-1:0]        mag;
  logic [PIX_W-1:0]     sat, result;
  logic                 border;

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk     (clk),
    .wr_en   (in_rd_en),
    .wr_addr (in_col),
    .wr_data (pixel_in),
    .rd_addr (in_col),
    .rd_data (lb1_out)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk     (clk),
    .wr_en   (in_rd_en),
    .wr_addr (in_col),
    .wr_data (lb1_out),
    .rd_addr (in_col),
    .rd_data (lb2_out)
  );

  assign col_new[0] = lb2_out;
  assign col_new[1] = lb1_out;
  assign col_new[2] = pixel_in;

  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    if (rst_n) begin
      case (state)
        FILL:    in_rd_en = !in_empty;
        STREAM: begin
          in_rd_en  = !in_empty && !out_full;
          out_wr_en = !in_empty && !out_full;
        end
        FLUSH:   out_wr_en = !out_full;
        default: ;
      endcase
    end
  end

  assign frame_done = out_wr_en && (state == FLUSH) &&
                      (out_row == LAST_ROW) && (out_col == LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      in_col   <= '0;
      in_row   <= '0;
      out_col  <= '0;
      out_row  <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      for (int i = 0; i < 3; i++) begin
        left_col[i]   <= '0;
        centre_col[i] <= '0;
      end
    end else begin
      if (in_rd_en) begin
        for (int i = 0; i < 3; i++) begin
          left_col[i]   <= centre_col[i];
          centre_col[i] <= col_new[i];
        end
        if (in_col == LAST_COL) begin
          in_col <= '0;
          in_row <= (in_row == LAST_ROW) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (out_wr_en) begin
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
      // Controls are frozen for the whole frame at its first pixel
      if (state == FILL && in_rd_en && in_row == '0 && in_col == '0) begin
        mode_q   <= mode;
        thresh_q <= threshold;
      end
      case (state)
        FILL:
          if (in_rd_en && in_row == RW'(1) && in_col == '0) state <= STREAM;
        STREAM:
          if (in_rd_en && in_row == LAST_ROW && in_col == LAST_COL) state <= FLUSH;
        FLUSH:
          if (frame_done) state <= FILL;
        default:
          state <= FILL;
      endcase
    end
  end

  function automatic logic [GW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return GW'(a) + (GW'(b) << 1) + GW'(c);
  endfunction

  assign gx = $signed(wsum(col_new[0], col_new[1], col_new[2])) -
              $signed(wsum(left_col[0], left_col[1], left_col[2]));
  assign gy = $signed(wsum(left_col[0], centre_col[0], col_new[0])) -
              $signed(wsum(left_col[2], centre_col[2], col_new[2]));

  assign abs_x = gx[GW-1] ? -gx : gx;
  assign abs_y = gy[GW-1] ? -gy : gy;

  assign border = (out_row == '0) || (out_row == LAST_ROW) ||
                  (out_col == '0) || (out_col == LAST_COL);

  // Stale window columns at a row wrap only ever feed border outputs
  always_comb begin
    case (mode_q)
      MODE_GX: mag = MW'(abs_x);
      MODE_GY: mag = MW'(abs_y);
      default: mag = MW'(abs_x) + MW'(abs_y);
    endcase
    sat    = (mag > MW'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
    result = sat;
    if (mode_q == MODE_THRESH) begin
      result = (sat > thresh_q) ? PIX_MAX : '0;
    end
    sobel_pixel = (out_wr_en && !border) ? result : '0;
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 image with hand-derived edge maps.
module tb_sobel_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int P = 8;
  localparam int N = W * H;
  localparam int NO_STALL = 1000000;
  localparam int BUDGET = 3000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_rd_en;
  logic         in_empty = 1'b1;
  logic [P-1:0] pixel_in = '0;
  logic         out_wr_en;
  logic         out_full = 1'b0;
  logic [P-1:0] sobel_pixel;
  logic [1:0]   mode = 2'd0;
  logic [P-1:0] threshold = '0;
  logic         frame_done;

  int checks = 0;
  int passed = 0;
  int done_cnt;
  logic [P-1:0] src_px [2*N];
  logic [P-1:0] cap [$];
  logic [P-1:0] ref_cap [$];

  sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_rd_en    (in_rd_en),
    .in_empty    (in_empty),
    .pixel_in    (pixel_in),
    .out_wr_en   (out_wr_en),
    .out_full    (out_full),
    .sobel_pixel (sobel_pixel),
    .mode        (mode),
    .threshold   (threshold),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // kind 0 = flat 100, kind 1 = vertical step between columns 3 and 4
  task automatic loadFrame(input int base, input int kind);
    for (int i = 0; i < N; i++) begin
      src_px[base + i] = (kind == 0) ? 8'd100 : (((i % W) >= 4) ? 8'd255 : 8'd0);
    end
  endtask

  function automatic logic [P-1:0] expPix(input int kind, input int i);
    int r;
    int c;
    r = i / W;
    c = i % W;
    if (kind == 1 && r >= 1 && r <= H - 2 && (c == 3 || c == 4)) return 8'd255;
    return 8'd0;
  endfunction

  task automatic applyStimulus(input int n_px, input int stop_reads, input bit gaps,
                               input int full_start, input int switch_at,
                               input logic [1:0] new_mode);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    cap.delete();
    done_cnt = 0;
    while (cap.size() < n_px && (stop_reads < 0 || idx < stop_reads) && cyc < BUDGET) begin
      @(negedge clk);
      if (idx == switch_at) mode = new_mode;
      in_empty = (idx >= n_px) || (gaps && $urandom_range(0, 3) == 0);
      pixel_in = (idx < n_px) ? src_px[idx] : '0;
      out_full = (cyc >= full_start) && (cyc < full_start + 5);
      #1;
      if (in_empty) checkOutput("no_read_when_empty", in_rd_en, 0);
      if (out_full) begin
        checkOutput("no_write_when_full", out_wr_en, 0);
        checkOutput("no_read_when_full", in_rd_en, 0);
      end
      if (!out_wr_en) checkOutput("idle_pixel_zero", sobel_pixel, 0);
      if (out_wr_en) cap.push_back(sobel_pixel);
      if (frame_done) done_cnt++;
      if (in_rd_en) idx++;
      cyc++;
    end
    checkOutput("cycle_budget", cyc < BUDGET, 1);
    @(negedge clk);
    in_empty = 1'b1;
    out_full = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input int kind, input int offset);
    for (int i = 0; i < N; i++) begin
      if (offset + i < cap.size())
        checkOutput($sformatf("%s_pix%0d", tag, i), cap[offset + i], expPix(kind, i));
    end
  endtask

  task automatic checkCounts(input string tag, input int writes, input int dones);
    checkOutput({tag, "_writes"}, cap.size(), writes);
    checkOutput({tag, "_frame_done"}, done_cnt, dones);
  endtask

  initial begin
    $display("[TB] sobel_stream %0dx%0d directed test", W, H);
    in_empty = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_rd_en", in_rd_en, 0);
    checkOutput("reset_wr_en", out_wr_en, 0);
    checkOutput("reset_pixel", sobel_pixel, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    @(negedge clk);
    in_empty = 1'b1;
    rst_n = 1'b1;

    loadFrame(0, 0);
    mode = 2'd0;
    applyStimulus(N, -1, 1'b0, NO_STALL, -1, 2'd0);
    checkCounts("flat", N, 1);
    checkFrame("flat", 0, 0);

    loadFrame(0, 1);
    applyStimulus(N, -1, 1'b0, NO_STALL, -1, 2'd0);
    checkCounts("step_m0", N, 1);
    checkFrame("step_m0", 1, 0);
    ref_cap = cap;

    mode = 2'd2;
    applyStimulus(N, -1, 1'b0, NO_STALL, -1, 2'd0);
    checkCounts("step_m2", N, 1);
    checkFrame("step_m2", 0, 0);

    mode = 2'd1;
    applyStimulus(N, -1, 1'b0, NO_STALL, -1, 2'd0);
    checkFrame("step_m1", 1, 0);

    mode = 2'd3;
    threshold = 8'd254;
    applyStimulus(N, -1, 1'b0, NO_STALL, -1, 2'd0);
    checkFrame("step_th254", 1, 0);
    threshold = 8'd255;
    applyStimulus(N, -1, 1'b0, NO_STALL, -1, 2'd0);
    checkFrame("step_th255", 0, 0);

    mode = 2'd0;
    threshold = 8'd0;
    applyStimulus(N, -1, 1'b1, 30, -1, 2'd0);
    checkCounts("stalled", N, 1);
    for (int i = 0; i < N; i++) begin
      if (i < cap.size()) checkOutput($sformatf("stalled_pix%0d", i), cap[i], ref_cap[i]);
    end

    applyStimulus(N, 20, 1'b0, NO_STALL, -1, 2'd0);
    in_empty = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_wr_en", out_wr_en, 0);
    checkOutput("midreset_rd_en", in_rd_en, 0);
    checkOutput("midreset_pixel", sobel_pixel, 0);
    @(negedge clk);
    in_empty = 1'b1;
    rst_n = 1'b1;
    applyStimulus(N, -1, 1'b0, NO_STALL, -1, 2'd0);
    checkCounts("after_reset", N, 1);
    checkFrame("after_reset", 1, 0);

    loadFrame(0, 1);
    loadFrame(N, 1);
    mode = 2'd2;
    applyStimulus(2 * N, -1, 1'b0, NO_STALL, 20, 2'd0);
    checkCounts("two_frames", 2 * N, 2);
    checkFrame("frame1_m2", 0, 0);
    checkFrame("frame2_m0", 1, N);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
